// File: rtl/mips_seq_pkg.sv
// rtl/mips_seq_pkg.sv - state encoding and PC source selectors for the MIPS cycle sequencer
package mips_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6,
    FAULT   = 3'd7
  } seq_state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/mips_wait_timer.sv
// rtl/mips_wait_timer.sv - consecutive not-ready cycle counter shared by FETCH and MEM
module mips_wait_timer
  import mips_seq_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ready,
  input  logic active,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              stalled;

  assign stalled = active & ~ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wait_cnt <= '0;
    end else if (stalled) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Fires during the MAX_WAIT-th consecutive stalled cycle so the next state is FAULT.
  assign expired = stalled & (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/mips_cycle_sequencer.sv
// rtl/mips_cycle_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with halt and fault trapping
module mips_cycle_sequencer
  import mips_seq_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dec_rw_ctrl,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_halt,
  input  logic             dec_illegal,
  input  logic             br_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  seq_state_t state;
  seq_state_t next_state;
  seq_state_t retire_target;
  logic       timer_clear;
  logic       timer_ready;
  logic       timer_active;
  logic       timer_expired;
  logic       mem_op;

  assign mem_op        = dec_mem_read | dec_mem_write;
  assign retire_target = run ? FETCH : IDLE;

  assign timer_active = (state == FETCH) || (state == MEM);
  assign timer_ready  = (state == FETCH) ? imem_ready : dmem_ready;
  // Restart the count on each fresh entry into a waiting state.
  assign timer_clear  = ((next_state == FETCH) || (next_state == MEM)) && (next_state != state);

  mips_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .ready   (timer_ready),
    .active  (timer_active),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        if (imem_ready)         next_state = DECODE;
        else if (timer_expired) next_state = FAULT;
      end
      DECODE: begin
        if (dec_illegal)                         next_state = FAULT;
        else if (dec_mem_read && dec_mem_write)  next_state = FAULT;
        else if (dec_halt)                       next_state = HALT;
        else                                     next_state = EXECUTE;
      end
      EXECUTE: begin
        if (dec_jump || dec_branch) next_state = retire_target;
        else if (mem_op)            next_state = MEM;
        else if (dec_rw_ctrl)       next_state = WB;
        else                        next_state = retire_target;
      end
      MEM: begin
        if (dmem_ready)         next_state = dec_mem_write ? retire_target : WB;
        else if (timer_expired) next_state = FAULT;
      end
      WB:      next_state = retire_target;
      HALT:    next_state = HALT;
      FAULT:   next_state = FAULT;
      default: next_state = FAULT;
    endcase
  end

  // Strobes are forced low during the reset cycle so no memory access can start.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    halted    = 1'b0;
    fault     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        EXECUTE: begin
          alu_en = 1'b1;
          if (dec_jump) begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
          end else if (dec_branch) begin
            pc_write = 1'b1;
            pc_src   = br_cond ? PC_BR : PC_SEQ;
          end else if (!mem_op && !dec_rw_ctrl) begin
            pc_write = 1'b1;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_mem_write;
          pc_write = dmem_ready & dec_mem_write;
        end
        WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        HALT:    halted = 1'b1;
        FAULT:   fault  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (pc_write && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// tb/tb_mips_cycle_sequencer.sv - randomized self-checking bench for mips_cycle_sequencer
module tb_mips_cycle_sequencer;

  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 16;

  localparam logic [10:0] W_IMEM = 11'h400;
  localparam logic [10:0] W_IR   = 11'h200;
  localparam logic [10:0] W_ALU  = 11'h100;
  localparam logic [10:0] W_DREQ = 11'h080;
  localparam logic [10:0] W_DWE  = 11'h040;
  localparam logic [10:0] W_RW   = 11'h020;
  localparam logic [10:0] W_PW   = 11'h010;
  localparam logic [10:0] W_JMP  = 11'h008;
  localparam logic [10:0] W_BR   = 11'h004;
  localparam logic [10:0] W_H    = 11'h002;
  localparam logic [10:0] W_F    = 11'h001;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JMP = 4, K_NOP = 5;
  localparam int K_HALT = 6, K_ILL = 7, K_BOTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic dec_rw_ctrl = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_branch = 1'b0;
  logic dec_jump = 1'b0, dec_halt = 1'b0, dec_illegal = 1'b0, br_cond = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_write, pc_write, halted, fault;
  logic [1:0] pc_src;
  logic [CNT_W-1:0] retired;
  logic [10:0] obs_w;

  always #5 clk = ~clk;

  mips_cycle_sequencer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .dec_rw_ctrl   (dec_rw_ctrl),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_branch    (dec_branch),
    .dec_jump      (dec_jump),
    .dec_halt      (dec_halt),
    .dec_illegal   (dec_illegal),
    .br_cond       (br_cond),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .ir_write      (ir_write),
    .alu_en        (alu_en),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .reg_write     (reg_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  assign obs_w = {imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_write, pc_write,
                  pc_src, halted, fault};

  typedef struct {
    logic [10:0] w;
    logic        imr;
    logic        dmr;
    logic        rn;
    logic [6:0]  dec;
    logic        bc;
    logic        ret;
  } step_t;

  step_t       sq[$];
  logic [6:0]  cur_dec;
  logic        cur_bc;
  logic [15:0] exp_ret = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [10:0] w, input logic imr, input logic dmr,
                      input logic rn, input logic ret);
    step_t s;
    s.w = w; s.imr = imr; s.dmr = dmr; s.rn = rn;
    s.dec = cur_dec; s.bc = cur_bc; s.ret = ret;
    sq.push_back(s);
  endtask

  task automatic push_idle(input logic rn);
    cur_dec = 7'($urandom);
    push(11'h000, rnd(), rnd(), rn, 1'b0);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, straight from the phase rules.
  task automatic build(input int kind, input int iw, input int dw, input logic bc,
                       input logic drop);
    logic rw, mr, mw, br, jp, hl, il;
    logic late_run;
    rw = (kind == K_ALU) || (kind == K_LOAD);
    mr = (kind == K_LOAD) || (kind == K_BOTH);
    mw = (kind == K_STORE) || (kind == K_BOTH);
    br = (kind == K_BR);
    jp = (kind == K_JMP);
    hl = (kind == K_HALT);
    il = (kind == K_ILL);
    cur_dec = {rw, mr, mw, br, jp, hl, il};
    cur_bc  = bc;
    for (int i = 0; i < iw && i < MAX_WAIT; i++) push(W_IMEM, 1'b0, rnd(), rnd(), 1'b0);
    if (iw >= MAX_WAIT) begin
      repeat (3) push(W_F, rnd(), rnd(), rnd(), 1'b0);
      return;
    end
    push(W_IMEM | W_IR, 1'b1, rnd(), rnd(), 1'b0);
    push(11'h000, rnd(), rnd(), rnd(), 1'b0);
    if (il || (mr && mw)) begin
      repeat (3) push(W_F, rnd(), rnd(), rnd(), 1'b0);
    end else if (hl) begin
      repeat (3) push(W_H, rnd(), rnd(), rnd(), 1'b0);
    end else if (jp) begin
      push(W_ALU | W_PW | W_JMP, rnd(), rnd(), !drop, 1'b1);
    end else if (br) begin
      push(W_ALU | W_PW | (bc ? W_BR : 11'h000), rnd(), rnd(), !drop, 1'b1);
    end else if (mr || mw) begin
      push(W_ALU, rnd(), rnd(), rnd(), 1'b0);
      for (int i = 0; i < dw && i < MAX_WAIT; i++) begin
        late_run = drop ? 1'b0 : rnd();
        push(W_DREQ | (mw ? W_DWE : 11'h000), rnd(), 1'b0, late_run, 1'b0);
      end
      if (dw >= MAX_WAIT) begin
        repeat (3) push(W_F, rnd(), rnd(), rnd(), 1'b0);
      end else if (mw) begin
        push(W_DREQ | W_DWE | W_PW, rnd(), 1'b1, !drop, 1'b1);
      end else begin
        late_run = drop ? 1'b0 : rnd();
        push(W_DREQ, rnd(), 1'b1, late_run, 1'b0);
        push(W_RW | W_PW, rnd(), rnd(), !drop, 1'b1);
      end
    end else if (rw) begin
      push(W_ALU, rnd(), rnd(), rnd(), 1'b0);
      push(W_RW | W_PW, rnd(), rnd(), !drop, 1'b1);
    end else begin
      push(W_ALU | W_PW, rnd(), rnd(), !drop, 1'b1);
    end
  endtask

  task automatic play(input string tag, input int limit);
    step_t s;
    int    n;
    n = 0;
    while (sq.size() > 0 && n < limit) begin
      s = sq.pop_front();
      @(negedge clk);
      rst = 1'b0;
      run = s.rn;
      imem_ready = s.imr;
      dmem_ready = s.dmr;
      {dec_rw_ctrl, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt, dec_illegal} = s.dec;
      br_cond = s.bc;
      #1;
      check({tag, "_strobes"}, 32'(obs_w), 32'(s.w));
      check({tag, "_retired"}, 32'(retired), 32'(exp_ret));
      if (s.ret) exp_ret = exp_ret + 16'd1;
      n++;
    end
    sq.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    run = rnd();
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check({tag, "_rst_cycle"}, 32'(obs_w), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    #1;
    exp_ret = '0;
    check({tag, "_rst_idle"}, 32'(obs_w), 32'h0);
    check({tag, "_rst_retired"}, 32'(retired), 32'h0);
  endtask

  initial begin
    do_reset("init");

    push_idle(1'b1);
    build(K_ALU, 0, 0, 1'b0, 1'b0);
    play("add", 1000);
    build(K_LOAD, 0, 3, 1'b0, 1'b0);
    play("load_wait3", 1000);
    build(K_BR, 0, 0, 1'b1, 1'b0);
    play("br_taken", 1000);
    build(K_BR, 0, 0, 1'b0, 1'b0);
    play("br_not_taken", 1000);
    build(K_JMP, 0, 0, 1'b0, 1'b0);
    build(K_NOP, 0, 0, 1'b0, 1'b0);
    build(K_STORE, 1, 2, 1'b0, 1'b0);
    play("jmp_nop_store", 1000);

    for (int i = 0; i < 40; i++) begin
      build($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), rnd(), 1'b0);
      play("random", 1000);
    end

    build(K_STORE, 0, 2, 1'b0, 1'b1);
    push_idle(1'b0);
    push_idle(1'b1);
    build(K_ALU, 0, 0, 1'b0, 1'b0);
    play("store_drop_run", 1000);

    build(K_ALU, 7, 0, 1'b0, 1'b0);
    build(K_LOAD, 0, 7, 1'b0, 1'b0);
    play("max_wait_minus1", 1000);

    build(K_ALU, 0, 0, 1'b0, 1'b0);
    build(K_HALT, 0, 0, 1'b0, 1'b0);
    play("syscall", 1000);
    do_reset("after_halt");

    push_idle(1'b1);
    build(K_ALU, 0, 0, 1'b0, 1'b0);
    build(K_ALU, 2, 0, 1'b0, 1'b0);
    build(K_HALT, 1, 0, 1'b0, 1'b0);
    play("two_alu_syscall", 1000);
    do_reset("after_halt2");

    push_idle(1'b1);
    build(K_ILL, 0, 0, 1'b0, 1'b0);
    play("illegal", 1000);
    do_reset("after_illegal");

    push_idle(1'b1);
    build(K_BOTH, 0, 0, 1'b0, 1'b0);
    play("rd_and_wr", 1000);
    do_reset("after_both");

    push_idle(1'b1);
    build(K_ALU, 0, 0, 1'b0, 1'b0);
    build(K_ALU, MAX_WAIT, 0, 1'b0, 1'b0);
    play("imem_timeout", 1000);
    do_reset("after_imem_timeout");

    push_idle(1'b1);
    build(K_STORE, 0, MAX_WAIT, 1'b0, 1'b0);
    play("dmem_timeout", 1000);
    do_reset("after_dmem_timeout");

    push_idle(1'b1);
    build(K_LOAD, 0, 5, 1'b0, 1'b0);
    play("mid_mem", 6);
    do_reset("mid_mem");

    push_idle(1'b1);
    build(K_JMP, 0, 0, 1'b0, 1'b0);
    play("post_reset_jmp", 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
